// File: rtl/pipe_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_shifter_pkg
// Description : Shared definitions for the pipelined barrel shifter: op
//               encodings, default widths, clog2 and the layout helpers for
//               the triangular per-stage shift-amount storage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_shifter_pkg;

    localparam int OP_W        = 2;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;
    localparam int DEF_TAG_W   = 5;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // Ceiling log2, used to size shift-amount fields from a data width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Stage k only keeps the shamt bits still to be applied (SHAMT_W-k of
    // them), so the stages are packed back to back into one flat vector.
    function automatic int shamt_off(input int shamt_w, input int stage);
        return stage * shamt_w - (stage * (stage - 1)) / 2;
    endfunction

    function automatic int shamt_bits(input int shamt_w);
        return (shamt_w * (shamt_w + 1)) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_shifter_if
// Description : Valid/ready operand and result bundle of the pipelined
//               shifter. master = producer/consumer side, slave = shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_shifter_if
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int TAG_W   = DEF_TAG_W
) ();

    logic               in_valid;
    logic               in_ready;
    op_e                in_op;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface
`default_nettype wire

// File: rtl/pipe_shifter_shift_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One combinational barrel-shifter level shifting by a fixed
//               distance DIST when enabled. Rotate support is compiled in
//               only when PIPE_SHIFTER_ROT_EN is defined; otherwise op 11
//               falls through to a logical right shift.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  op_e              op_i,
    input  logic             fill_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    // Apply this level's fixed shift; the SRA fill bit comes from the
    // original operand sign so every level fills identically.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SLL:  data_o = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
                OP_SRA:  data_o = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
`ifdef PIPE_SHIFTER_ROT_EN
                OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
`endif
                default: data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_shifter
// Description : Fully pipelined SLL/SRL/SRA(/ROR) barrel shifter with a
//               valid/ready handshake, tag passthrough and flush. Each stage
//               register feeds one shift level, MSB shamt bit first, so the
//               result is SHAMT_W cycles behind the input handshake.
//               Optional rotate: define PIPE_SHIFTER_ROT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_shifter
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    pipe_shifter_if.slave bus
);

    localparam int SH_BITS = shamt_bits(SHAMT_W);
    localparam int LAST    = SHAMT_W - 1;

    logic [SHAMT_W-1:0] valid_q;
    logic [SHAMT_W-1:0] valid_d;
    logic [SHAMT_W-1:0] load_w;
    op_e                op_q      [SHAMT_W];
    logic [SHAMT_W-1:0] fill_q;
    logic [WIDTH-1:0]   data_q    [SHAMT_W];
    logic [WIDTH-1:0]   shifted_w [SHAMT_W];
    logic [TAG_W-1:0]   tag_q     [SHAMT_W];
    logic [SH_BITS-1:0] shamt_q;

    // A stage may load when it, or any stage downstream of it, is empty, or
    // the consumer is taking the result; this collapses bubbles under stall.
    always_comb begin
        logic chain;
        chain  = bus.out_ready;
        load_w = '0;
        for (int k = SHAMT_W - 1; k >= 0; k--) begin
            chain     = chain | ~valid_q[k];
            load_w[k] = chain;
        end
    end

    // Valid bits advance with each stage load; flush empties the whole pipe
    // and drops whatever is offered on the input that cycle.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            if (load_w[0]) begin
                valid_d[0] = bus.in_valid;
            end
            for (int k = 1; k < SHAMT_W; k++) begin
                if (load_w[k]) begin
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    // Only the valid bits are reset; everything else is qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload registers capture on stage load; stage k keeps only the shamt
    // bits that the remaining levels still need.
    always_ff @(posedge clk) begin
        if (load_w[0]) begin
            data_q[0] <= bus.in_data;
            op_q[0]   <= bus.in_op;
            fill_q[0] <= bus.in_data[WIDTH-1];
            tag_q[0]  <= bus.in_tag;
            for (int b = 0; b < SHAMT_W; b++) begin
                shamt_q[b] <= bus.in_shamt[b];
            end
        end
        for (int k = 1; k < SHAMT_W; k++) begin
            if (load_w[k]) begin
                data_q[k] <= shifted_w[k-1];
                op_q[k]   <= op_q[k-1];
                fill_q[k] <= fill_q[k-1];
                tag_q[k]  <= tag_q[k-1];
                for (int b = 0; b < SHAMT_W - k; b++) begin
                    shamt_q[shamt_off(SHAMT_W, k) + b] <= shamt_q[shamt_off(SHAMT_W, k-1) + b];
                end
            end
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
        localparam int DIST   = 1 << (SHAMT_W - 1 - k);
        localparam int EN_BIT = shamt_off(SHAMT_W, k) + SHAMT_W - 1 - k;

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (DIST)
        ) u_level (
            .data_i (data_q[k]),
            .op_i   (op_q[k]),
            .fill_i (fill_q[k]),
            .en_i   (shamt_q[EN_BIT]),
            .data_o (shifted_w[k])
        );
    end

    // in_ready is forced high during flush since the pipe is being emptied.
    assign bus.in_ready  = load_w[0] | flush_i;
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = valid_q[LAST] ? shifted_w[LAST] : '0;
    assign bus.out_tag   = valid_q[LAST] ? tag_q[LAST]     : '0;

endmodule
`default_nettype wire
